rs_syndrome_calc: RTL

- Streaming Reed-Solomon syndrome stage. It sits directly downstream of the received-codeword interface and directly upstream of the key-equation solver.
- Evaluates the received polynomial at 2*T consecutive roots of GF(2^8), using field polynomial 0x11B and primitive element alpha = 0x03.
- Uses 2*T GF(256) constant-root multipliers, one per syndrome, in Horner form.
- Accepts one symbol per cycle and emits all syndromes plus an error-present flag once per codeword.

---
 rtl/rs_syndrome_calc_if.sv | 25 ++
 rtl/rs_syndrome_calc.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_calc_if.sv
// Streaming handshake bundle for the Reed-Solomon syndrome stage: symbol input
// and syndrome-bundle output channels.
interface rs_syndrome_calc_if #(
   parameter int unsigned T = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              in_last;
   logic              syn_valid;
   logic              syn_ready;
   logic [16*T-1:0]   syn_data;
   logic              syn_nonzero;
   logic              len_err;

   modport master (
      output in_valid, in_data, in_last, syn_ready,
      input  in_ready, syn_valid, syn_data, syn_nonzero, len_err
   );

   modport slave (
      input  in_valid, in_data, in_last, syn_ready,
      output in_ready, syn_valid, syn_data, syn_nonzero, len_err
   );
endinterface

// File: rtl/rs_syndrome_calc.sv
// Streaming RS syndrome calculator over GF(2^8)/0x11B, alpha = 0x03, Horner form.
// Optional length checking is enabled with macro RS_SYN_LEN_CHECK_EN.
module rs_syndrome_calc #(
   parameter int unsigned T   = 8,
   parameter int unsigned N   = 255,
   parameter int unsigned FCR = 0
) (
   input logic               clk,
   input logic               rst,
   rs_syndrome_calc_if.slave bus
);

   localparam int unsigned NumSyn = 2 * T;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDone
   } state_e;

   // Carry-less 8x8 product followed by reduction of the 15-bit result.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ (15'(a) << i);
      end
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
      end
      return p[7:0];
   endfunction

   function automatic logic [7:0] gf_pow(input int unsigned e);
      logic [7:0]  r;
      logic [7:0]  base;
      int unsigned x;
      r    = 8'h01;
      base = 8'h03;
      x    = e % 255;
      for (int b = 0; b < 8; b++) begin
         if (((x >> b) & 1) != 0) r = gf_mul(r, base);
         base = gf_mul(base, base);
      end
      return r;
   endfunction

   if (N < 2 || N > 255) begin : g_bad_n
      $error("rs_syndrome_calc: N must lie in 2..255");
   end

   state_e     state_q, state_d;
   logic [7:0] syn_q [NumSyn];
   logic [7:0] syn_d [NumSyn];
   logic [7:0] horner [NumSyn];
   logic [7:0] cnt_q, cnt_d;
   logic       nz_q, nz_d;
   logic [7:0] cnt_inc;
   logic       accept;
   logic       end_cw;
   logic       any_nz;
   logic [16*T-1:0] syn_flat;

   for (genvar j = 0; j < NumSyn; j++) begin : g_root
      localparam logic [7:0] Root = gf_pow(FCR + j);
      assign horner[j] = gf_mul(syn_q[j], Root) ^ bus.in_data;
   end

   assign bus.in_ready  = (state_q != StDone);
   assign bus.syn_valid = (state_q == StDone);
   assign accept        = bus.in_valid && bus.in_ready;
   assign cnt_inc       = (state_q == StIdle) ? 8'd1 :
                          (cnt_q == 8'hFF)    ? 8'hFF : cnt_q + 8'd1;

`ifdef RS_SYN_LEN_CHECK_EN
   localparam logic [7:0] NLen = 8'(N);
   logic len_err_q, len_err_d;

   // Reaching N symbols without in_last also closes the codeword.
   assign end_cw      = bus.in_last || (cnt_inc == NLen);
   assign bus.len_err = len_err_q;

   always_comb begin
      len_err_d = len_err_q;
      if (accept && end_cw) begin
         len_err_d = bus.in_last ? (cnt_inc != NLen) : 1'b1;
      end else if (state_q == StDone && bus.syn_ready) begin
         len_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_err_q <= 1'b0;
      end else begin
         len_err_q <= len_err_d;
      end
   end
`else
   assign end_cw      = bus.in_last;
   assign bus.len_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      syn_d   = syn_q;
      cnt_d   = cnt_q;
      nz_d    = nz_q;
      any_nz  = 1'b0;
      unique case (state_q)
         StIdle, StAccum: begin
            if (accept) begin
               for (int unsigned j = 0; j < NumSyn; j++) begin
                  syn_d[j] = (state_q == StIdle) ? bus.in_data : horner[j];
                  any_nz   = any_nz | (|syn_d[j]);
               end
               cnt_d = cnt_inc;
               if (end_cw) begin
                  state_d = StDone;
                  nz_d    = any_nz;
               end else begin
                  state_d = StAccum;
               end
            end
         end
         StDone: begin
            if (bus.syn_ready) begin
               state_d = StIdle;
               cnt_d   = 8'd0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      syn_flat = '0;
      for (int unsigned j = 0; j < NumSyn; j++) begin
         syn_flat[8*j +: 8] = syn_q[j];
      end
   end

   assign bus.syn_data    = syn_flat;
   assign bus.syn_nonzero = nz_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         nz_q    <= 1'b0;
         for (int unsigned j = 0; j < NumSyn; j++) begin
            syn_q[j] <= 8'd0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nz_q    <= nz_d;
         syn_q   <= syn_d;
      end
   end

endmodule
